mon_alarm_sched: RTL and testbench
==================================

Name: mon_alarm_sched

Overview:
- Multi-channel consecutive-event monitor controller.
- NCH channels each count consecutive cycles with their event input high, and raise a pending alarm when count > a shared programmable threshold.
- A round-robin scheduler shares one alarm-report port (valid/ready) between channels.
- A global FSM arms, disarms and reconfigures all channels.
- Sits between raw event sources and the system alarm/interrupt logic.

Parameters:
- NCH, 4, number of monitored channels (2..8)
- CW, 6, counter and threshold width
- HOLDOFF, 8, cycles a channel ignores events after its alarm is reported (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- evnt  in  NCH  per-channel event inputs, sampled each clk
- arm  in  1  pulse: IDLE->RUN
- disarm  in  1  pulse: RUN->IDLE
- cfg_load  in  1  pulse: load cfg_thresh into the threshold register
- cfg_thresh  in  CW  new threshold value
- rpt_valid  out  1  alarm report valid
- rpt_ready  in  1  consumer accepts report
- rpt_ch  out  clog2(NCH)  channel being reported
- rpt_count  out  CW  channel count at grant time
- alarm_any  out  1  OR of all channel pending flags
- running  out  1  global FSM is in RUN

Behaviour:
- Reset values: threshold 0, global state IDLE, all counters 0, all channels ARMED, RR pointer 0, rpt_valid 0, rpt_ch 0, rpt_count 0, alarm_any 0, running 0.
- Global FSM:
  - IDLE: counters held at 0, no pending, rpt_valid 0. arm -> RUN.
  - RUN: disarm -> IDLE. In the same cycle, all counters and channel states clear and any in-flight report is dropped (rpt_valid low next cycle).
  - arm and disarm in the same cycle: disarm wins.
- cfg_load in any state:
  - threshold <= cfg_thresh.
  - All counters clear, all channels go to ARMED, in-flight report dropped.
  - Global state is unchanged.
- Per-channel counter update rule, RUN and channel ARMED only:
  - If cnt > thresh: hold.
  - Else if evnt: cnt+1.
  - Else: cnt = 0.
  - Comparison is unsigned. The counter saturates at all-ones, so with thresh = 2^CW-1 the channel never alarms.
- Channel states:
  - ARMED -> PENDING when cnt > thresh (combinational on the registered cnt).
  - PENDING -> HOLD on the cycle its report handshakes (rpt_valid & rpt_ready with rpt_ch = this channel).
  - HOLD: cnt forced to 0 and evnt ignored for exactly HOLDOFF cycles, then back to ARMED.
- Latency: if the edge-k update makes cnt = thresh+1, then alarm_any is high after edge k and rpt_valid is high after edge k+1 at the earliest.
- Scheduler:
  - When rpt_valid is low and any channel is PENDING, grant the first pending channel at or after the RR pointer (wrapping). Register rpt_valid=1, rpt_ch, and rpt_count.
  - On handshake the RR pointer becomes granted+1 mod NCH.
  - rpt_valid, rpt_ch and rpt_count stay stable until rpt_ready. The only exceptions are rst, disarm and cfg_load, which abort the report.
  - A new grant may issue the cycle after a handshake, so back-to-back reports run at one per 2 cycles minimum.
- Simultaneous events: multiple channels crossing in the same cycle are served in RR order. A channel never re-enters PENDING while PENDING.
- A channel whose evnt drops while PENDING stays PENDING; its count is latched.

Optional Feature:
- Macro MON_STICKY_ALARM_EN.
- Defined: after a report handshake the channel enters LOCKED instead of HOLD. LOCKED means cnt frozen, no further reports. It leaves LOCKED only on disarm, cfg_load or rst. An extra output sticky_mask (NCH bits) shows the LOCKED channels.
- Undefined: HOLD/holdoff re-arm as above. No sticky_mask port.

Decomposition:
- Package mon_pkg holds:
  - Global state enum {G_IDLE, G_RUN}.
  - Channel state enum {CH_ARMED, CH_PENDING, CH_HOLD, CH_LOCKED}.
  - Default NCH/CW/HOLDOFF constants.
- Sub-module mon_chan: per-channel counter, state and holdoff timer. Inputs are clear, enable, evnt, thresh and grant_ack; outputs are pending and cnt. It is instantiated NCH times.
- The top level holds the global FSM, threshold register and RR arbiter.

Test Plan:
- Basic alarm: rst, cfg_thresh=3 load, arm; evnt[0] high 4 cycles with rpt_ready=1 -> rpt_valid one cycle, rpt_ch=0, rpt_count=4; no report for the next 8 cycles despite evnt.
- Broken run: thresh=3, evnt[1] high 3 cycles, low 1, high 3 -> no report, counter returns to 0.
- Round robin: thresh=1, evnt[0..3] all high together, rpt_ready held 0 for 5 cycles then 1 -> reports for ch 0,1,2,3 in that order, data stable while stalled.
- Abort: report valid on ch2 with rpt_ready=0, pulse cfg_load with thresh=5 -> rpt_valid 0 next cycle, all counters 0, new threshold in effect.
- Edge threshold: thresh=63, evnt[0] high 100 cycles -> counter saturates at 63, no alarm_any; disarm+arm same cycle -> remains IDLE.
- Sticky (MON_STICKY_ALARM_EN): alarm ch3 acknowledged -> sticky_mask=4'b1000, no further ch3 reports until disarm.

Source files
------------

// File: rtl/mon_pkg.sv
// Shared types and default sizing for the consecutive-event alarm monitor.
// Optional feature macro: MON_STICKY_ALARM_EN (reported channels lock until disarm/cfg_load/rst).
package mon_pkg;

    localparam int MON_NCH_DEF     = 4;
    localparam int MON_CW_DEF      = 6;
    localparam int MON_HOLDOFF_DEF = 8;

    // Width of the per-channel holdoff timer; HOLDOFF is limited to 1..255.
    localparam int MON_HOLD_W      = 8;

    typedef enum logic {
        G_IDLE,
        G_RUN
    } g_state_e;

    typedef enum logic [1:0] {
        CH_ARMED,
        CH_PENDING,
        CH_HOLD,
        CH_LOCKED
    } ch_state_e;

endpackage

// File: rtl/mon_chan.sv
// One monitored channel: consecutive-event counter, alarm state and holdoff timer.
// Optional feature macro: MON_STICKY_ALARM_EN (after its report the channel locks
// with a frozen count instead of entering holdoff; exposes a locked flag).
module mon_chan
    import mon_pkg::*;
#(
    parameter int CW      = MON_CW_DEF,
    parameter int HOLDOFF = MON_HOLDOFF_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic          evnt,
    input  logic [CW-1:0] thresh,
    input  logic          grant_ack,
    output logic          pending,
    output logic [CW-1:0] cnt
`ifdef MON_STICKY_ALARM_EN
    ,
    output logic          locked
`endif
);

    localparam logic [CW-1:0]         CNT_MAX  = {CW{1'b1}};
    localparam logic [MON_HOLD_W-1:0] HOLD_LD  = MON_HOLD_W'(HOLDOFF - 1);

    ch_state_e             r_state;
    logic [CW-1:0]         r_cnt;
    logic [MON_HOLD_W-1:0] r_hold;
    logic                  w_over;

    // Threshold crossing is judged on the registered count so the alarm is visible one edge after the crossing update.
    assign w_over = (r_cnt > thresh);

    // Counter, channel state and holdoff timer; a global clear or an idle monitor returns the channel to ARMED with count 0.
    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            r_state <= CH_ARMED;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                CH_ARMED: begin
                    if (w_over) begin
                        r_state <= CH_PENDING;
                    end else if (evnt) begin
                        // Saturating increment: with thresh at all-ones the channel can never alarm.
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                CH_PENDING: begin
                    // Count stays latched while waiting for the report port.
                    if (grant_ack) begin
`ifdef MON_STICKY_ALARM_EN
                        r_state <= CH_LOCKED;
`else
                        r_state <= CH_HOLD;
                        r_cnt   <= '0;
                        r_hold  <= HOLD_LD;
`endif
                    end
                end
                CH_HOLD: begin
                    r_cnt <= '0;
                    if (r_hold == '0) begin
                        r_state <= CH_ARMED;
                    end else begin
                        r_hold <= r_hold - MON_HOLD_W'(1);
                    end
                end
                CH_LOCKED: begin
                    // Frozen until the whole monitor is cleared.
                end
                default: begin
                    r_state <= CH_ARMED;
                end
            endcase
        end
    end

    assign pending = enable &&
                     ((r_state == CH_PENDING) || ((r_state == CH_ARMED) && w_over));
    assign cnt     = r_cnt;

`ifdef MON_STICKY_ALARM_EN
    assign locked  = (r_state == CH_LOCKED);
`endif

endmodule

// File: rtl/mon_alarm_sched.sv
// Multi-channel consecutive-event monitor with a global arm/disarm FSM, a shared
// threshold register and a round-robin scheduler feeding one valid/ready report port.
// Optional feature macro: MON_STICKY_ALARM_EN (adds sticky_mask of locked channels).
module mon_alarm_sched
    import mon_pkg::*;
#(
    parameter int NCH     = MON_NCH_DEF,
    parameter int CW      = MON_CW_DEF,
    parameter int HOLDOFF = MON_HOLDOFF_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           evnt,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic                     cfg_load,
    input  logic [CW-1:0]            cfg_thresh,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [$clog2(NCH)-1:0]   rpt_ch,
    output logic [CW-1:0]            rpt_count,
    output logic                     alarm_any,
    output logic                     running
`ifdef MON_STICKY_ALARM_EN
    ,
    output logic [NCH-1:0]           sticky_mask
`endif
);

    localparam int CHW = $clog2(NCH);

    g_state_e               r_gstate;
    g_state_e               w_gstate_next;
    logic [CW-1:0]          r_thresh;

    logic                   r_rpt_valid;
    logic [CHW-1:0]         r_rpt_ch;
    logic [CW-1:0]          r_rpt_count;
    logic [CHW-1:0]         r_rr_ptr;

    logic                   w_enable;
    logic                   w_abort;
    logic                   w_hs;
    logic [NCH-1:0]         w_pending;
    logic [NCH-1:0]         w_grant_ack;
    logic [NCH-1:0][CW-1:0] w_cnt;
    logic                   w_gnt_found;
    logic [CHW-1:0]         w_gnt_idx;

    // Global state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gstate <= G_IDLE;
        end else begin
            r_gstate <= w_gstate_next;
        end
    end

    // Global next-state: disarm dominates arm in either state.
    always_comb begin
        w_gstate_next = r_gstate;
        case (r_gstate)
            G_IDLE:  if (arm && !disarm) w_gstate_next = G_RUN;
            G_RUN:   if (disarm)         w_gstate_next = G_IDLE;
            default: w_gstate_next = G_IDLE;
        endcase
    end

    // Global FSM outputs.
    always_comb begin
        running  = (r_gstate == G_RUN);
        w_enable = (r_gstate == G_RUN);
    end

    // Reconfiguration or leaving RUN wipes every channel and drops any report in flight.
    assign w_abort = cfg_load || ((r_gstate == G_RUN) && disarm);
    assign w_hs    = r_rpt_valid && rpt_ready;

    // Shared threshold register; loadable in any global state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_thresh <= '0;
        end else if (cfg_load) begin
            r_thresh <= cfg_thresh;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            assign w_grant_ack[gi] = w_hs && (r_rpt_ch == CHW'(gi));

            mon_chan #(
                .CW      (CW),
                .HOLDOFF (HOLDOFF)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .clear     (w_abort),
                .enable    (w_enable),
                .evnt      (evnt[gi]),
                .thresh    (r_thresh),
                .grant_ack (w_grant_ack[gi]),
                .pending   (w_pending[gi]),
                .cnt       (w_cnt[gi])
`ifdef MON_STICKY_ALARM_EN
                ,
                .locked    (sticky_mask[gi])
`endif
            );
        end
    endgenerate

    // Round-robin pick: scan from the farthest offset down so the nearest pending channel at/after the pointer wins.
    always_comb begin
        logic [CHW:0] v_idx;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        v_idx       = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            v_idx = {1'b0, r_rr_ptr} + (CHW+1)'(k);
            if (v_idx >= (CHW+1)'(NCH)) begin
                v_idx = v_idx - (CHW+1)'(NCH);
            end
            if (w_pending[v_idx[CHW-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = v_idx[CHW-1:0];
            end
        end
    end

    // Report register: hold a grant stable until accepted, then advance the pointer past the served channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt_valid <= 1'b0;
            r_rpt_ch    <= '0;
            r_rpt_count <= '0;
            r_rr_ptr    <= '0;
        end else if (w_abort) begin
            r_rpt_valid <= 1'b0;
        end else if (r_rpt_valid) begin
            if (rpt_ready) begin
                r_rpt_valid <= 1'b0;
                r_rr_ptr    <= (r_rpt_ch == CHW'(NCH - 1)) ? '0 : r_rpt_ch + CHW'(1);
            end
        end else if (w_gnt_found) begin
            r_rpt_valid <= 1'b1;
            r_rpt_ch    <= w_gnt_idx;
            r_rpt_count <= w_cnt[w_gnt_idx];
        end
    end

    assign rpt_valid = r_rpt_valid;
    assign rpt_ch    = r_rpt_ch;
    assign rpt_count = r_rpt_count;
    assign alarm_any = |w_pending;

endmodule

// File: tb/tb_mon_alarm_sched.sv
// Directed bench for mon_alarm_sched (NCH=4, CW=6, HOLDOFF=8).
// Inputs change and outputs are sampled on the falling edge.
// With MON_STICKY_ALARM_EN defined, the locked-channel scenario is also exercised.
module tb_mon_alarm_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] evnt;
    logic       arm;
    logic       disarm;
    logic       cfg_load;
    logic [5:0] cfg_thresh;
    logic       rpt_valid;
    logic       rpt_ready;
    logic [1:0] rpt_ch;
    logic [5:0] rpt_count;
    logic       alarm_any;
    logic       running;
`ifdef MON_STICKY_ALARM_EN
    logic [3:0] sticky_mask;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mon_alarm_sched #(
        .NCH     (4),
        .CW      (6),
        .HOLDOFF (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .evnt       (evnt),
        .arm        (arm),
        .disarm     (disarm),
        .cfg_load   (cfg_load),
        .cfg_thresh (cfg_thresh),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_ch     (rpt_ch),
        .rpt_count  (rpt_count),
        .alarm_any  (alarm_any),
        .running    (running)
`ifdef MON_STICKY_ALARM_EN
        ,
        .sticky_mask(sticky_mask)
`endif
    );

    // One line per accepted report.
    always @(posedge clk) begin
        if (!rst && rpt_valid && rpt_ready) begin
            $display("[%0t] report accepted: ch=%0d count=%0d", $time, rpt_ch, rpt_count);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; evnt = '0; arm = 1'b0; disarm = 1'b0;
        cfg_load = 1'b0; cfg_thresh = '0; rpt_ready = 1'b0;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic load_and_arm(input logic [5:0] th);
        cfg_thresh = th; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_valid",   rpt_valid, 0);
        chk("rst_ch",      rpt_ch,    0);
        chk("rst_count",   rpt_count, 0);
        chk("rst_alarm",   alarm_any, 0);
        chk("rst_running", running,   0);

        // ---------------- basic alarm + holdoff ----------------
        load_and_arm(6'd3);
        chk("t1_running", running, 1);
        rpt_ready = 1'b1;
        evnt = 4'b0001;
        ticks(3);                               // cnt = 3, not above threshold
        chk("t1_alarm_cnt3", alarm_any, 0);
        tick();                                 // cnt = 4 > 3
        chk("t1_alarm_cnt4", alarm_any, 1);
        chk("t1_valid_early", rpt_valid, 0);
        tick();                                 // grant registered
        chk("t1_valid", rpt_valid, 1);
        chk("t1_ch",    rpt_ch,    0);
        chk("t1_count", rpt_count, 4);
        tick();                                 // handshake, channel enters holdoff
        chk("t1_valid_hs", rpt_valid, 0);
        chk("t1_alarm_hs", alarm_any, 0);
        for (int i = 0; i < 8; i++) begin       // events ignored during holdoff
            tick();
            chk("t1_hold_valid", rpt_valid, 0);
            chk("t1_hold_alarm", alarm_any, 0);
        end
        ticks(3);                               // counting resumes: cnt = 3
        chk("t1_rearm_cnt3", alarm_any, 0);
        tick();                                 // cnt = 4
        chk("t1_rearm_alarm", alarm_any, 1);
        evnt = 4'b0000;
        tick();
        chk("t1_rearm_valid", rpt_valid, 1);
        chk("t1_rearm_count", rpt_count, 4);
        tick();
        chk("t1_rearm_hs", rpt_valid, 0);

        // ---------------- broken run ----------------
        evnt = 4'b0010; ticks(3);
        chk("t2_alarm_a", alarm_any, 0);
        evnt = 4'b0000; tick();
        evnt = 4'b0010; ticks(3);
        chk("t2_alarm_b", alarm_any, 0);
        chk("t2_valid_b", rpt_valid, 0);
        evnt = 4'b0000; tick();                 // counter back to 0
        evnt = 4'b0010; ticks(3);               // only 3 again -> still below
        chk("t2_alarm_c", alarm_any, 0);
        evnt = 4'b0000; tick();
        chk("t2_valid_c", rpt_valid, 0);

        // ---------------- round robin with stall ----------------
        do_reset();
        load_and_arm(6'd1);
        rpt_ready = 1'b0;
        evnt = 4'b1111;
        ticks(2);                               // cnt = 2 on all channels
        chk("t3_alarm", alarm_any, 1);
        evnt = 4'b0000;                         // pending counts stay latched
        tick();
        chk("t3_valid0", rpt_valid, 1);
        chk("t3_ch0",    rpt_ch,    0);
        chk("t3_cnt0",   rpt_count, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_valid", rpt_valid, 1);
            chk("t3_stall_ch",    rpt_ch,    0);
            chk("t3_stall_cnt",   rpt_count, 2);
        end
        rpt_ready = 1'b1;
        tick();
        chk("t3_hs0", rpt_valid, 0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t3_valid_k", rpt_valid, 1);
            chk("t3_ch_k",    rpt_ch,    k);
            chk("t3_cnt_k",   rpt_count, 2);
            tick();
            chk("t3_hs_k",    rpt_valid, 0);
        end
        chk("t3_alarm_done", alarm_any, 0);

        // ---------------- abort by cfg_load ----------------
        ticks(10);                              // let holdoffs expire
        rpt_ready = 1'b0;
        evnt = 4'b0100;
        ticks(3);
        chk("t4_valid", rpt_valid, 1);
        chk("t4_ch",    rpt_ch,    2);
        chk("t4_cnt",   rpt_count, 2);
        cfg_thresh = 6'd5; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        chk("t4_abort_valid", rpt_valid, 0);
        chk("t4_abort_alarm", alarm_any, 0);
        chk("t4_running",     running,   1);
        ticks(5);                               // cnt = 5, not above new threshold
        chk("t4_cnt5_alarm", alarm_any, 0);
        chk("t4_cnt5_valid", rpt_valid, 0);
        tick();                                 // cnt = 6
        chk("t4_cnt6_alarm", alarm_any, 1);
        tick();
        chk("t4_new_valid", rpt_valid, 1);
        chk("t4_new_ch",    rpt_ch,    2);
        chk("t4_new_cnt",   rpt_count, 6);
        rpt_ready = 1'b1; evnt = 4'b0000;
        tick();
        chk("t4_new_hs", rpt_valid, 0);

        // ---------------- abort by disarm ----------------
        do_reset();
        load_and_arm(6'd0);
        evnt = 4'b0010;
        tick();
        chk("t5_alarm", alarm_any, 1);
        tick();
        chk("t5_valid", rpt_valid, 1);
        chk("t5_ch",    rpt_ch,    1);
        chk("t5_cnt",   rpt_count, 1);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("t5_dis_valid",   rpt_valid, 0);
        chk("t5_dis_running", running,   0);
        tick();                                 // idle: events ignored
        chk("t5_idle_alarm",  alarm_any, 0);
        evnt = 4'b0000;

        // ---------------- saturation at all-ones threshold ----------------
        do_reset();
        load_and_arm(6'd63);
        rpt_ready = 1'b1;
        evnt = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("t6_sat_alarm", alarm_any, 0);
            chk("t6_sat_valid", rpt_valid, 0);
        end
        evnt = 4'b0000;
        arm = 1'b1; disarm = 1'b1;              // in RUN: disarm wins
        tick();
        chk("t6_both_run", running, 0);
        tick();                                 // in IDLE: still disarm wins
        arm = 1'b0; disarm = 1'b0;
        chk("t6_both_idle", running, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t6_rearm", running, 1);

`ifdef MON_STICKY_ALARM_EN
        // ---------------- sticky lock ----------------
        do_reset();
        load_and_arm(6'd1);
        rpt_ready = 1'b1;
        evnt = 4'b1000;
        ticks(3);
        chk("t7_valid", rpt_valid, 1);
        chk("t7_ch",    rpt_ch,    3);
        tick();
        chk("t7_mask", sticky_mask, 4'b1000);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t7_locked_valid", rpt_valid, 0);
        end
        chk("t7_mask_hold", sticky_mask, 4'b1000);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("t7_mask_clr", sticky_mask, 4'b0000);
        evnt = 4'b0000;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
